// File: rtl/stmt_lowerer_seq_dispatch_if.sv
// Command/beat handshake bundle for the statement-lowering sequence dispatcher.
// The master drives commands and consumes beats; the slave is the dispatcher.
interface stmt_lowerer_seq_dispatch_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_chan;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_chan, out_data, out_last
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_chan, out_data, out_last
    );
endinterface

// File: rtl/stmt_lowerer_seq_dispatch.sv
// Accepts one selector-tagged command at a time and emits it as one beat or as
// a BURST-beat incrementing sequence on a decoded channel, counting completions.
module stmt_lowerer_seq_dispatch #(
    parameter int WIDTH = 8,
    parameter int BURST = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    stmt_lowerer_seq_dispatch_if.slave bus,
    output logic [7:0]                cmd_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        BURST_ST = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

    state_t           state_r, state_s;
    logic             valid_r, valid_s;
    logic [1:0]       chan_r, chan_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic             last_r, last_s;
    logic [3:0]       cnt_r, cnt_s;
    logic [7:0]       count_r, count_s;

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            chan_r  <= 2'd0;
            data_r  <= '0;
            last_r  <= 1'b0;
            cnt_r   <= 4'd0;
            count_r <= 8'd0;
        end else begin
            state_r <= state_s;
            valid_r <= valid_s;
            chan_r  <= chan_s;
            data_r  <= data_s;
            last_r  <= last_s;
            cnt_r   <= cnt_s;
            count_r <= count_s;
        end
    end

    // Next-state and next-output decode; everything holds unless a transfer occurs.
    always_comb begin
        state_s = state_r;
        valid_s = valid_r;
        chan_s  = chan_r;
        data_s  = data_r;
        last_s  = last_r;
        cnt_s   = cnt_r;
        count_s = count_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    valid_s = 1'b1;
                    data_s  = bus.in_data;
                    casez (bus.in_sel)
                        2'b0?: begin
                            chan_s  = 2'd0;
                            cnt_s   = 4'd0;
                            last_s  = 1'b1;
                            state_s = SEND;
                        end
                        2'b10: begin
                            chan_s  = 2'd1;
                            cnt_s   = 4'd0;
                            last_s  = 1'b1;
                            state_s = SEND;
                        end
                        2'b11: begin
                            chan_s  = 2'd2;
                            cnt_s   = BURST_LAST;
                            last_s  = (BURST_LAST == 4'd0);
                            state_s = BURST_ST;
                        end
                        default: begin
                            chan_s  = 2'd0;
                            cnt_s   = 4'd0;
                            last_s  = 1'b1;
                            state_s = SEND;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                    count_s = count_r + 8'd1;
                end else begin
                    state_s = SEND;
                end
            end
            BURST_ST: begin
                if (bus.out_ready) begin
                    if (cnt_r != 4'd0) begin
                        data_s  = data_r + {{(WIDTH-1){1'b0}}, 1'b1};
                        cnt_s   = cnt_r - 4'd1;
                        last_s  = (cnt_r == 4'd1);
                        state_s = BURST_ST;
                    end else begin
                        state_s = IDLE;
                        valid_s = 1'b0;
                        last_s  = 1'b0;
                        count_s = count_r + 8'd1;
                    end
                end else begin
                    state_s = BURST_ST;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                last_s  = 1'b0;
                cnt_s   = 4'd0;
            end
        endcase
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = valid_r;
    assign bus.out_chan  = chan_r;
    assign bus.out_data  = data_r;
    assign bus.out_last  = last_r;
    assign cmd_count     = count_r;
endmodule

// File: tb/tb_stmt_lowerer_seq_dispatch.sv
// Randomized and directed bench for stmt_lowerer_seq_dispatch against a
// queue-of-beats reference model.
module tb_stmt_lowerer_seq_dispatch;
    localparam int WIDTH = 8;
    localparam int BURST = 3;

    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] cmd_count;
    int         total;
    int         bad;
    beat_t      q[$];
    logic [7:0] exp_cnt;

    stmt_lowerer_seq_dispatch_if #(.WIDTH(WIDTH)) ifc ();

    stmt_lowerer_seq_dispatch #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc),
        .cmd_count (cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare outputs against the model, drive inputs, then advance the model
    // over the coming rising edge.
    task automatic cycle(input logic iv, input logic [1:0] sel, input logic [7:0] d, input logic ordy);
        int    n;
        logic [1:0] ch;
        beat_t b;
        @(negedge clk);
        chk("in_ready", {31'd0, ifc.in_ready}, {31'd0, q.size() == 0});
        chk("out_valid", {31'd0, ifc.out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_chan", {30'd0, ifc.out_chan}, {30'd0, q[0].chan});
            chk("out_data", {24'd0, ifc.out_data}, {24'd0, q[0].data});
            chk("out_last", {31'd0, ifc.out_last}, {31'd0, q[0].last});
        end else begin
            chk("idle_last", {31'd0, ifc.out_last}, 32'd0);
        end
        chk("cmd_count", {24'd0, cmd_count}, {24'd0, exp_cnt});
        ifc.in_valid  = iv;
        ifc.in_sel    = sel;
        ifc.in_data   = d;
        ifc.out_ready = ordy;
        if (q.size() != 0) begin
            if (ordy) begin
                b = q.pop_front();
                if (b.last) exp_cnt = exp_cnt + 8'd1;
            end
        end else if (iv) begin
            n  = (sel == 2'b11) ? BURST : 1;
            ch = (sel == 2'b11) ? 2'd2 : (sel == 2'b10) ? 2'd1 : 2'd0;
            for (int i = 0; i < n; i++) begin
                b.chan = ch;
                b.data = d + 8'(i);
                b.last = (i == n - 1);
                q.push_back(b);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, ifc.in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'd0, ifc.out_valid}, 32'd0);
        chk({tag, "_out_chan"}, {30'd0, ifc.out_chan}, 32'd0);
        chk({tag, "_out_data"}, {24'd0, ifc.out_data}, 32'd0);
        chk({tag, "_out_last"}, {31'd0, ifc.out_last}, 32'd0);
        chk({tag, "_cmd_count"}, {24'd0, cmd_count}, 32'd0);
    endtask

    // Asynchronous reset mid-cycle, after the model's pending edge has passed.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        ifc.in_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        exp_cnt = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_cnt = 8'd0;
        rst_n = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_sel    = 2'b00;
        ifc.in_data   = 8'h00;
        ifc.out_ready = 1'b0;
        #3;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single beat, channel 0
        cycle(1'b1, 2'b01, 8'h5A, 1'b1);
        repeat (3) cycle(1'b0, 2'b11, 8'hC3, 1'b1);
        // wildcard decode and channel 1
        cycle(1'b1, 2'b00, 8'h11, 1'b1);
        repeat (2) cycle(1'b0, 2'b00, 8'h00, 1'b1);
        cycle(1'b1, 2'b10, 8'h33, 1'b1);
        repeat (2) cycle(1'b0, 2'b00, 8'h00, 1'b1);
        // burst with data wrap
        cycle(1'b1, 2'b11, 8'hFE, 1'b1);
        repeat (5) cycle(1'b0, 2'b01, 8'h99, 1'b1);
        cycle(1'b1, 2'b11, 8'hFF, 1'b1);
        repeat (5) cycle(1'b0, 2'b01, 8'h99, 1'b1);
        // backpressure on second beat
        cycle(1'b1, 2'b11, 8'h40, 1'b1);
        cycle(1'b1, 2'b01, 8'hAA, 1'b1);
        repeat (4) cycle(1'b1, 2'b10, 8'hBB, 1'b0);
        repeat (3) cycle(1'b0, 2'b00, 8'h00, 1'b1);
        // back-to-back with in_valid held
        repeat (8) cycle(1'b1, 2'b10, 8'h21, 1'b1);
        repeat (2) cycle(1'b0, 2'b00, 8'h00, 1'b1);
        // reset after first burst beat
        cycle(1'b1, 2'b11, 8'h80, 1'b1);
        cycle(1'b0, 2'b00, 8'h00, 1'b1);
        mid_reset();
        cycle(1'b1, 2'b10, 8'h77, 1'b1);
        repeat (3) cycle(1'b0, 2'b00, 8'h00, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom), ($urandom_range(0, 3) != 0));
        end
        // enough single commands to wrap cmd_count
        for (int i = 0; i < 600; i++) begin
            cycle(1'b1, 2'b01, 8'(i), 1'b1);
        end
        repeat (3) cycle(1'b0, 2'b00, 8'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stmt_lowerer_seq_dispatch.md
STMT_LOWERER_SEQ_DISPATCH -- requirements
Module: stmt_lowerer_seq_dispatch

Interface
REQ-001 Parameter WIDTH, default 8, data path width in bits.
REQ-002 Parameter BURST, default 3, beats emitted for a burst command; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream command valid.
REQ-006 in_ready  output  1  block can accept a command.
REQ-007 in_sel  input  2  command selector.
REQ-008 in_data  input  WIDTH  command payload.
REQ-009 out_valid  output  1  output beat valid.
REQ-010 out_ready  input  1  downstream accepts beat.
REQ-011 out_chan  output  2  destination channel of current beat.
REQ-012 out_data  output  WIDTH  beat payload.
REQ-013 out_last  output  1  current beat is final beat of its command.
REQ-014 cmd_count  output  8  completed-command counter.

Function
REQ-015 Transfer rule: input accepted on a rising edge where in_valid && in_ready; output beat consumed on a rising edge where out_valid && out_ready.
REQ-016 FSM states SHALL be IDLE, SEND, BURST; encoding free.
REQ-017 in_ready SHALL equal 1 exactly when state is IDLE; combinational from state only, never from in_valid.
REQ-018 Decode at acceptance, wildcard priority: in_sel 2'b0? -> channel 0, 1 beat, next SEND; 2'b10 -> channel 1, 1 beat, next SEND; 2'b11 -> channel 2, BURST beats, next BURST.
REQ-019 On acceptance: out_data <= in_data, out_chan <= decoded channel, out_valid <= 1, beat counter <= beats-1, out_last <= (beats==1).
REQ-020 Latency: command accepted on edge k SHALL present its first beat with out_valid=1 from edge k to edge k+1 onward (one-cycle registered latency).
REQ-021 While out_valid && !out_ready, out_data, out_chan, out_last SHALL hold stable.
REQ-022 SEND: on beat consumption -> IDLE, out_valid <= 0, out_last <= 0, cmd_count increments.
REQ-023 BURST: on consumption with beat counter > 0 -> out_data <= out_data+1 modulo 2^WIDTH, counter decrements, out_last <= (counter==1), stay BURST.
REQ-024 BURST: on consumption with beat counter == 0 -> IDLE, out_valid <= 0, out_last <= 0, cmd_count increments.
REQ-025 cmd_count SHALL wrap 255 -> 0 without flag.
REQ-026 No new command accepted while SEND/BURST; in_valid held by upstream is accepted on the first cycle back in IDLE (edge after final consumption + 1), giving one bubble cycle between commands.
REQ-027 out_data increment SHALL wrap: WIDTH=8, in_data 8'hFF burst -> beats FF, 00, 01.
REQ-028 in_sel/in_data SHALL be ignored when no transfer occurs.
REQ-029 out_valid SHALL never depend combinationally on out_ready.

Reset
REQ-030 While rst_n=0: state IDLE, out_valid=0, out_chan=0, out_data=0, out_last=0, cmd_count=0, beat counter=0, in_ready=1; no transfers occur.
REQ-031 Reset asserted mid-command SHALL abandon the command immediately; no beat and no count increment issued after deassertion.
REQ-032 First acceptance possible on first rising edge with rst_n=1.

Verification
REQ-033 Single: sel=2'b01, data=8'h5A, out_ready=1 -> one beat chan=0, data=5A, last=1; cmd_count 0->1; in_ready back to 1 next cycle.
REQ-034 Wildcard priority: sel=2'b00 and 2'b01 both -> chan 0; sel=2'b10 data=8'h33 -> chan 1, single beat.
REQ-035 Burst with wrap: sel=2'b11, data=8'hFE, BURST=3 -> beats FE, FF, 00 on chan 2, last=1 only on 00; cmd_count +1.
REQ-036 Backpressure: burst with out_ready low 4 cycles on second beat -> data/chan/last stable throughout; sequence unchanged; in_ready 0 for whole command.
REQ-037 Back-to-back: in_valid held high with two commands -> exactly one idle cycle (in_ready=1, out_valid=0) between them; both counted.
REQ-038 Reset mid-burst after first beat -> outputs zero immediately, cmd_count=0; after release a new sel=2'b10 command completes normally.
